// File: rtl/csr_pkg.sv
// Shared constants for the CSR access unit: Zicsr funct3 codes, FSM states
// and the address prefix that marks read-only CSRs.
package csr_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } csr_state_t;

    // funct3[1:0]==00 covers both reserved encodings (000 and 100).
    function automatic logic csr_is_illegal(input logic [2:0] funct3);
        return (funct3[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle of request, response and CSR-file signals of the CSR access unit.
// slave = the access unit itself, master = its environment (decode + CSR file).
interface csr_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_csr;
    logic [DATA_W-1:0] req_rs1_val;
    logic [4:0]        req_zimm;
    logic              req_rs1_zero;
    logic              req_rd_zero;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              csr_read_en;
    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_rdata;
    logic              csr_write_en;
    logic [ADDR_W-1:0] csr_wb_addr;
    logic [DATA_W-1:0] csr_wb_data;

    modport slave (
        input  req_valid, req_funct3, req_csr, req_rs1_val, req_zimm,
               req_rs1_zero, req_rd_zero, resp_ready, csr_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               csr_read_en, csr_addr, csr_write_en, csr_wb_addr, csr_wb_data
    );

    modport master (
        output req_valid, req_funct3, req_csr, req_rs1_val, req_zimm,
               req_rs1_zero, req_rd_zero, resp_ready, csr_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               csr_read_en, csr_addr, csr_write_en, csr_wb_addr, csr_wb_data
    );
endinterface

// File: rtl/csr_alu.sv
// Combinational modify step of a CSR read-modify-write:
// write replaces, set ORs in the source bits, clear masks them out.
module csr_alu #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_src,
    output logic [DATA_W-1:0] o_new
);
    always_comb begin
        o_new = i_src;
        case (i_op)
            2'b01:   o_new = i_src;
            2'b10:   o_new = i_old | i_src;
            2'b11:   o_new = i_old & ~i_src;
            default: o_new = i_src;
        endcase
    end
endmodule

// File: rtl/csr_access_unit.sv
// Executes one Zicsr instruction as IDLE -> READ -> WRITE -> DONE against the CSR file.
// Build option CSR_RO_CHECK_EN: block writes to CSRs whose top address bits are 2'b11.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    csr_access_unit_if.slave  bus
);
    csr_state_t        r_state;
    csr_state_t        w_state_next;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_csr;
    logic [DATA_W-1:0] r_src;
    logic              r_rs1_zero;
    logic              r_rd_zero;
    logic [DATA_W-1:0] r_old;
    logic              r_err;

    logic              w_accept;
    logic              w_is_rw;
    logic              w_read_allowed;
    logic              w_write_attempt;
    logic              w_ro_block;
    logic              w_req_ready;
    logic              w_resp_valid;
    logic              w_read_en;
    logic              w_write_en;
    logic [DATA_W-1:0] w_src_in;
    logic [DATA_W-1:0] w_alu_new;

    assign w_accept        = (r_state == ST_IDLE) && bus.req_valid;
    assign w_src_in        = bus.req_funct3[2] ? {{(DATA_W-5){1'b0}}, bus.req_zimm}
                                               : bus.req_rs1_val;
    assign w_is_rw         = (r_op == 2'b01);
    // RW forms with rd=x0 must not read (side-effecting reads); set/clear with rs1=x0 must not write.
    assign w_read_allowed  = !(w_is_rw && r_rd_zero);
    assign w_write_attempt = !(!w_is_rw && r_rs1_zero);

`ifdef CSR_RO_CHECK_EN
    assign w_ro_block = w_write_attempt && (r_csr[ADDR_W-1:ADDR_W-2] == CSR_RO_PREFIX);
`else
    assign w_ro_block = 1'b0;
`endif

    csr_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op  (r_op),
        .i_old (r_old),
        .i_src (r_src),
        .o_new (w_alu_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_read_en    = 1'b0;
        w_write_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_next = csr_is_illegal(bus.req_funct3) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_read_en    = w_read_allowed;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_write_en   = w_write_attempt && !w_ro_block;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request latch and old-value/error capture; r_err is pre-set at accept for illegal funct3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_csr      <= '0;
            r_src      <= '0;
            r_rs1_zero <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_old      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= bus.req_funct3[1:0];
                r_csr      <= bus.req_csr;
                r_src      <= w_src_in;
                r_rs1_zero <= bus.req_rs1_zero;
                r_rd_zero  <= bus.req_rd_zero;
                r_old      <= '0;
                r_err      <= csr_is_illegal(bus.req_funct3);
            end
            if (r_state == ST_READ) begin
                r_old <= w_read_allowed ? bus.csr_rdata : '0;
            end
            if ((r_state == ST_WRITE) && w_ro_block) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.resp_valid   = w_resp_valid;
    assign bus.resp_rdata   = w_resp_valid ? r_old : '0;
    assign bus.resp_err     = w_resp_valid ? r_err : 1'b0;
    assign bus.csr_read_en  = w_read_en;
    assign bus.csr_addr     = r_csr;
    assign bus.csr_write_en = w_write_en;
    assign bus.csr_wb_addr  = r_csr;
    assign bus.csr_wb_data  = w_write_en ? w_alu_new : '0;

endmodule
